// File: rtl/rio_pkg.sv
// rio_pkg: watchdog state type, default headers and frame field offsets
// shared by rio_frame_io and rio_watchdog.
package rio_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUN,
    EXPIRED
  } wd_state_t;

  localparam logic [31:0] HEADER_RX_DEF = 32'h74697277;
  localparam logic [31:0] HEADER_TX_DEF = 32'h64617461;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int rx_hdr_msb(input int bs);
    return bs - 1;
  endfunction

  function automatic int rx_vel_msb(input int bs, input int ch);
    return bs - 33 - 32 * ch;
  endfunction

  function automatic int rx_en_bit(input int bs, input int chans,
                                   input int ch);
    return bs - 33 - 32 * chans - ch;
  endfunction

  function automatic int tx_ts_msb(input int bs);
    return bs - 33;
  endfunction

  function automatic int tx_pos_msb(input int bs, input int ch);
    return bs - 65 - 32 * ch;
  endfunction

endpackage

// File: rtl/rio_watchdog.sv
// rio_watchdog: traffic watchdog; saturating counter plus
// WAIT_FIRST/RUN/EXPIRED state machine kicked by accepted frames.
module rio_watchdog
  import rio_pkg::*;
#(
  parameter int TIMEOUT = 2700000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic kick,
  output logic timeout,
  output logic expire_pulse
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  wd_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state <= WAIT_FIRST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A kick always wins over expiry, even when cnt == LIMIT.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    expire_pulse = 1'b0;
    unique case (state)
      WAIT_FIRST: begin
        if (kick) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (kick) begin
          cnt_nx = '0;
        end else if (cnt == LIMIT) begin
          state_nx     = EXPIRED;
          expire_pulse = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      EXPIRED: begin
        if (kick) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = WAIT_FIRST;
        cnt_nx   = '0;
      end
    endcase
  end

  assign timeout = (state != RUN);

endmodule

// File: rtl/rio_frame_io.sv
// rio_frame_io: unpacks N velocity/enable channels from the PC frame and
// snapshots positions into the TX frame. Option: RIO_RX_CHECKSUM_EN.
module rio_frame_io
  import rio_pkg::*;
#(
  parameter int          BUFFER_SIZE = 160,
  parameter int          CHANNELS    = 3,
  parameter int          TIMEOUT     = 2700000,
  parameter logic [31:0] HEADER_RX   = HEADER_RX_DEF,
  parameter logic [31:0] HEADER_TX   = HEADER_TX_DEF
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     sync,
  input  logic [BUFFER_SIZE-1:0]   rx_data,
  output logic [BUFFER_SIZE-1:0]   tx_data,
  input  logic [32*CHANNELS-1:0]   positions,
  output logic [32*CHANNELS-1:0]   velocities,
  output logic [CHANNELS-1:0]      enables,
  output logic                     timeout,
  output logic                     frame_valid,
  output logic [15:0]              frame_cnt,
  output logic [15:0]              err_cnt
);

  localparam int BS      = BUFFER_SIZE;
  localparam int CH      = CHANNELS;
  localparam int VW      = 32 * CHANNELS;
  localparam int HDR_MSB = rx_hdr_msb(BS);
  localparam int TS_MSB  = tx_ts_msb(BS);
  localparam int POS_MSB = tx_pos_msb(BS, 0);

  logic [2:0]    sync_sr;
  logic          sync_edge;
  logic [31:0]   timestamp;
  logic          hdr_ok;
  logic [VW-1:0] rx_vel;
  logic [CH-1:0] rx_en;
  logic [BS-1:0] tx_next;
  logic          acc_strobe;
  logic          acc_ok;
  logic [VW-1:0] acc_vel;
  logic [CH-1:0] acc_en;
  logic          accept;
  logic          reject;
  logic          expire;
  logic [CH-1:0] lat_en;
  logic          unused_rx;

  assign unused_rx = ^rx_data;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) sync_sr <= '0;
    else     sync_sr <= {sync_sr[1:0], sync};
  end

  assign sync_edge = (sync_sr[2:1] == 2'b01);

  assign hdr_ok = (byte_swap32(rx_data[HDR_MSB -: 32]) == HEADER_RX);

  for (genvar i = 0; i < CH; i++) begin : g_rx
    localparam int VM = rx_vel_msb(BS, i);
    localparam int EB = rx_en_bit(BS, CH, i);
    assign rx_vel[32*i +: 32] = byte_swap32(rx_data[VM -: 32]);
    assign rx_en[i]           = rx_data[EB];
  end

`ifdef RIO_RX_CHECKSUM_EN
  localparam int NB = BS / 8;

  logic [7:0]    rx_xor;
  logic          pend;
  logic          pend_ok;
  logic [VW-1:0] vel_q;
  logic [CH-1:0] en_q;

  always_comb begin
    rx_xor = '0;
    for (int b = 1; b < NB; b++) rx_xor ^= rx_data[8*b +: 8];
  end

  // Header and checksum verdict are staged one cycle with the fields.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      pend_ok <= 1'b0;
      vel_q   <= '0;
      en_q    <= '0;
    end else begin
      pend    <= sync_edge;
      pend_ok <= hdr_ok && (rx_xor == rx_data[7:0]);
      vel_q   <= rx_vel;
      en_q    <= rx_en;
    end
  end

  assign acc_strobe = pend;
  assign acc_ok     = pend_ok;
  assign acc_vel    = vel_q;
  assign acc_en     = en_q;
`else
  assign acc_strobe = sync_edge;
  assign acc_ok     = hdr_ok;
  assign acc_vel    = rx_vel;
  assign acc_en     = rx_en;
`endif

  assign accept = acc_strobe & acc_ok;
  assign reject = acc_strobe & ~acc_ok;

  rio_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .sysclk       (sysclk),
    .rst          (rst),
    .kick         (accept),
    .timeout      (timeout),
    .expire_pulse (expire)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      velocities  <= '0;
      lat_en      <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= accept;
      if (expire) begin
        velocities <= '0;
        lat_en     <= '0;
      end
      if (accept) begin
        velocities <= acc_vel;
        lat_en     <= acc_en;
        frame_cnt  <= frame_cnt + 16'd1;
      end
      if (reject && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign enables = lat_en & ~{CH{timeout}};

  always_comb begin
    tx_next = '0;
    tx_next[BS-1 -: 32]   = byte_swap32(HEADER_TX);
    tx_next[TS_MSB -: 32] = byte_swap32(timestamp);
    for (int i = 0; i < CH; i++)
      tx_next[POS_MSB - 32*i -: 32] = byte_swap32(positions[32*i +: 32]);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      timestamp <= '0;
      tx_data   <= {byte_swap32(HEADER_TX), {(BS-32){1'b0}}};
    end else begin
      timestamp <= timestamp + 32'd1;
      if (sync_edge) tx_data <= tx_next;
    end
  end

endmodule

// File: tb/tb_rio_frame_io.sv
// tb_rio_frame_io: randomized frame traffic against a byte-level
// reference model of the RX/TX layouts and the watchdog timing.
`timescale 1ns/1ps
module tb_rio_frame_io;

  localparam int BS  = 160;
  localparam int CH  = 3;
  localparam int TO  = 100;
  localparam int NB  = BS / 8;
  localparam logic [31:0] HRX = 32'h74697277;
`ifdef RIO_RX_CHECKSUM_EN
  localparam int LAT = 2;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit CHK = 1'b0;
`endif

  logic              sysclk;
  logic              rst;
  logic              sync;
  logic [BS-1:0]     rx_data;
  logic [BS-1:0]     tx_data;
  logic [32*CH-1:0]  positions;
  logic [32*CH-1:0]  velocities;
  logic [CH-1:0]     enables;
  logic              timeout;
  logic              frame_valid;
  logic [15:0]       frame_cnt;
  logic [15:0]       err_cnt;

  rio_frame_io #(
    .BUFFER_SIZE (BS),
    .CHANNELS    (CH),
    .TIMEOUT     (TO)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .sync        (sync),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .positions   (positions),
    .velocities  (velocities),
    .enables     (enables),
    .timeout     (timeout),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0]   ts_m;
  int            since;
  bit            ever;
  logic [31:0]   vel_m [CH];
  logic [CH-1:0] en_m;
  logic [15:0]   fc_m;
  logic [15:0]   ec_m;
  bit            last_acc;

  logic [31:0]   stim_hdr;
  logic [31:0]   stim_vel [CH];
  logic [CH-1:0] stim_en;
  bit            stim_bad;
  logic [BS-1:0] exp_tx;

  bit watch_to = 1'b0;
  bit seen_to = 1'b0;

  always @(negedge sysclk)
    if (watch_to && timeout === 1'b1) seen_to = 1'b1;

  function automatic logic [32*CH-1:0] exp_vel();
    logic [32*CH-1:0] v;
    for (int i = 0; i < CH; i++) v[32*i +: 32] = vel_m[i];
    return v;
  endfunction

  function automatic bit exp_to();
    return !ever || since > TO;
  endfunction

  function automatic logic [CH-1:0] exp_en();
    return exp_to() ? '0 : en_m;
  endfunction

  task automatic step();
    @(posedge sysclk);
    ts_m++;
    since++;
    if (ever && since == TO + 1) begin
      for (int i = 0; i < CH; i++) vel_m[i] = '0;
      en_m = '0;
    end
    @(negedge sysclk);
  endtask

  task automatic model_reset();
    ts_m = '0; since = 0; ever = 1'b0;
    fc_m = '0; ec_m = '0; en_m = '0;
    for (int i = 0; i < CH; i++) vel_m[i] = '0;
  endtask

  task automatic load_rx();
    logic [7:0]  by [NB];
    logic [7:0]  x;
    logic [31:0] w;
    for (int k = 0; k < NB; k++) by[k] = 8'($urandom);
    w = stim_hdr;
    for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
    for (int i = 0; i < CH; i++) begin
      w = stim_vel[i];
      for (int k = 0; k < 4; k++) by[4 + 4*i + k] = w[8*k +: 8];
    end
    for (int i = 0; i < CH; i++) by[4 + 4*CH][7-i] = stim_en[i];
    x = '0;
    for (int k = 0; k < NB - 1; k++) x ^= by[k];
    if (CHK) by[NB-1] = stim_bad ? ~x : x;
    for (int k = 0; k < NB; k++) rx_data[BS-1-8*k -: 8] = by[k];
  endtask

  task automatic make_tx(input logic [31:0] ts);
    logic [7:0]  by [NB];
    logic [31:0] w;
    for (int k = 0; k < NB; k++) by[k] = '0;
    w = 32'h64617461;
    for (int k = 0; k < 4; k++) by[k] = w[8*k +: 8];
    for (int k = 0; k < 4; k++) by[4 + k] = ts[8*k +: 8];
    for (int i = 0; i < CH; i++) begin
      w = positions[32*i +: 32];
      for (int k = 0; k < 4; k++) by[8 + 4*i + k] = w[8*k +: 8];
    end
    for (int k = 0; k < NB; k++) exp_tx[BS-1-8*k -: 8] = by[k];
  endtask

  task automatic rand_stim();
    for (int i = 0; i < CH; i++) stim_vel[i] = $urandom;
    stim_en = CH'($urandom);
  endtask

  // 2 idle + 2 sync cycles + edge cycle + (LAT-1): accept on step 4+LAT
  task automatic run_frame(input logic [31:0] hdr, input bit bad_csum);
    stim_hdr = hdr;
    stim_bad = bad_csum;
    sync = 1'b0;
    step();
    step();
    load_rx();
    sync = 1'b1;
    step();
    step();
    make_tx(ts_m);
    step();
    for (int k = 1; k < LAT; k++) step();
    last_acc = (hdr == HRX) && !(CHK && bad_csum);
    if (last_acc) begin
      since = 0;
      ever = 1'b1;
      for (int i = 0; i < CH; i++) vel_m[i] = stim_vel[i];
      en_m = stim_en;
      fc_m++;
    end else if (ec_m != 16'hFFFF) begin
      ec_m++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sync = 1'b0;
    step();
    step();
    compared++;
    if (timeout !== 1'b1 || enables !== '0 || frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got to=%b en=%b fv=%b want 1/0/0",
               timeout, enables, frame_valid);
    end
    compared++;
    if (velocities !== '0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_regs: got vel=%h fc=%0d ec=%0d want zeros",
               velocities, frame_cnt, err_cnt);
    end
    make_tx(32'd0);
    for (int i = 0; i < CH; i++) exp_tx[BS-65-32*i -: 32] = '0;
    compared++;
    if (tx_data !== exp_tx) begin
      mismatched++;
      $display("FAIL reset_tx: got %h want %h", tx_data, exp_tx);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    logic [31:0] h;
    h = 32'h61746164;
    repeat (TO + 10) step();
    compared++;
    if (timeout !== 1'b1 || enables !== '0) begin
      mismatched++;
      $display("FAIL idle_timeout: got to=%b en=%b want 1/0",
               timeout, enables);
    end
    compared++;
    if (tx_data[BS-1 -: 32] !== h) begin
      mismatched++;
      $display("FAIL idle_tx_hdr: got %h want %h", tx_data[BS-1 -: 32], h);
    end
  endtask

  task automatic test_valid();
    rand_stim();
    stim_vel[0] = 32'h10;
    stim_en = 3'b101;
    run_frame(HRX, 1'b0);
    compared++;
    if (velocities !== exp_vel() || velocities[31:0] !== 32'h10) begin
      mismatched++;
      $display("FAIL valid_vel: got %h want %h", velocities, exp_vel());
    end
    compared++;
    if (enables !== 3'b101 || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_en: got en=%b to=%b want 101/0", enables, timeout);
    end
    compared++;
    if (frame_valid !== 1'b1 || frame_cnt !== fc_m) begin
      mismatched++;
      $display("FAIL valid_count: got fv=%b fc=%0d want 1/%0d",
               frame_valid, frame_cnt, fc_m);
    end
    compared++;
    if (tx_data !== exp_tx) begin
      mismatched++;
      $display("FAIL valid_tx: got %h want %h", tx_data, exp_tx);
    end
    step();
    compared++;
    if (frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_pulse: got fv=%b want 0", frame_valid);
    end
  endtask

  task automatic test_bad_header();
    rand_stim();
    run_frame(32'hDEADBEEF, 1'b0);
    compared++;
    if (velocities !== exp_vel() || enables !== exp_en()) begin
      mismatched++;
      $display("FAIL badhdr_hold: got vel=%h en=%b want %h/%b",
               velocities, enables, exp_vel(), exp_en());
    end
    compared++;
    if (err_cnt !== ec_m || frame_cnt !== fc_m || frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL badhdr_cnt: got ec=%0d fc=%0d fv=%b want %0d/%0d/0",
               err_cnt, frame_cnt, frame_valid, ec_m, fc_m);
    end
    while (since < TO) step();
    compared++;
    if (timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL badhdr_wd_pre: got to=%b want 0", timeout);
    end
    step();
    compared++;
    if (timeout !== 1'b1 || velocities !== '0 || enables !== '0) begin
      mismatched++;
      $display("FAIL badhdr_wd_exp: got to=%b vel=%h en=%b want 1/0/0",
               timeout, velocities, enables);
    end
  endtask

  task automatic test_timeout();
    rand_stim();
    stim_en = '1;
    run_frame(HRX, 1'b0);
    compared++;
    if (velocities !== exp_vel() || enables !== exp_en() || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL to_restore1: got vel=%h en=%b to=%b want %h/%b/0",
               velocities, enables, timeout, exp_vel(), exp_en());
    end
    repeat (TO) step();
    compared++;
    if (timeout !== 1'b0 || enables !== exp_en()) begin
      mismatched++;
      $display("FAIL to_at_limit: got to=%b en=%b want 0/%b",
               timeout, enables, exp_en());
    end
    step();
    compared++;
    if (timeout !== 1'b1 || velocities !== '0 || enables !== '0) begin
      mismatched++;
      $display("FAIL to_expire: got to=%b vel=%h en=%b want 1/0/0",
               timeout, velocities, enables);
    end
    rand_stim();
    run_frame(HRX, 1'b0);
    compared++;
    if (velocities !== exp_vel() || enables !== exp_en() || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL to_restore2: got vel=%h en=%b to=%b want %h/%b/0",
               velocities, enables, timeout, exp_vel(), exp_en());
    end
  endtask

  task automatic test_boundary();
    seen_to = 1'b0;
    watch_to = 1'b1;
    repeat (TO - 3 - LAT - since) step();
    rand_stim();
    run_frame(HRX, 1'b0);
    repeat (3) step();
    watch_to = 1'b0;
    compared++;
    if (seen_to !== 1'b0 || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL boundary_to: got seen=%b to=%b want 0/0",
               seen_to, timeout);
    end
    compared++;
    if (velocities !== exp_vel() || enables !== exp_en()) begin
      mismatched++;
      $display("FAIL boundary_out: got vel=%h en=%b want %h/%b",
               velocities, enables, exp_vel(), exp_en());
    end
  endtask

  task automatic test_tx_hold();
    logic [BS-1:0] held;
    for (int i = 0; i < CH; i++) positions[32*i +: 32] = $urandom;
    positions[63:32] = 32'h01020304;
    rand_stim();
    run_frame(HRX, 1'b0);
    held = exp_tx;
    compared++;
    if (tx_data !== held || tx_data[BS-97 -: 32] !== 32'h04030201) begin
      mismatched++;
      $display("FAIL tx_snap: got %h want %h", tx_data, held);
    end
    repeat (5) begin
      for (int i = 0; i < CH; i++) positions[32*i +: 32] = $urandom;
      step();
    end
    compared++;
    if (tx_data !== held) begin
      mismatched++;
      $display("FAIL tx_hold: got %h want %h", tx_data, held);
    end
    run_frame(HRX, 1'b0);
    compared++;
    if (tx_data !== exp_tx) begin
      mismatched++;
      $display("FAIL tx_update: got %h want %h", tx_data, exp_tx);
    end
  endtask

  task automatic test_checksum();
    rand_stim();
    run_frame(HRX, 1'b1);
    compared++;
    if (frame_cnt !== fc_m || err_cnt !== ec_m || frame_valid !== last_acc) begin
      mismatched++;
      $display("FAIL csum_cnt: got fc=%0d ec=%0d fv=%b want %0d/%0d/%b",
               frame_cnt, err_cnt, frame_valid, fc_m, ec_m, last_acc);
    end
    compared++;
    if (velocities !== exp_vel() || enables !== exp_en()) begin
      mismatched++;
      $display("FAIL csum_out: got vel=%h en=%b want %h/%b",
               velocities, enables, exp_vel(), exp_en());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < CH; i++) positions[32*i +: 32] = $urandom;
      rand_stim();
      h = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) ^ HRX : HRX;
      run_frame(h, $urandom_range(0, 4) == 0);
      compared++;
      if (velocities !== exp_vel() || enables !== exp_en() ||
          timeout !== exp_to()) begin
        mismatched++;
        $display("FAIL b2b_out[%0d]: got vel=%h en=%b to=%b want %h/%b/%b",
                 n, velocities, enables, timeout, exp_vel(), exp_en(),
                 exp_to());
      end
      compared++;
      if (frame_cnt !== fc_m || err_cnt !== ec_m ||
          frame_valid !== last_acc || tx_data !== exp_tx) begin
        mismatched++;
        $display("FAIL b2b_cnt[%0d]: got fc=%0d ec=%0d fv=%b tx=%h want %0d/%0d/%b/%h",
                 n, frame_cnt, err_cnt, frame_valid, tx_data,
                 fc_m, ec_m, last_acc, exp_tx);
      end
    end
  endtask

  task automatic test_reset_midframe();
    rand_stim();
    stim_hdr = HRX;
    stim_bad = 1'b0;
    sync = 1'b0;
    step();
    step();
    load_rx();
    sync = 1'b1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    compared++;
    if (frame_cnt !== 16'd0 || velocities !== '0 || timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_async: got fc=%0d vel=%h to=%b want 0/0/1",
               frame_cnt, velocities, timeout);
    end
    @(negedge sysclk);
    sync = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    repeat (4) step();
    compared++;
    if (frame_cnt !== 16'd0 || frame_valid !== 1'b0 || enables !== '0 ||
        err_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL midrst_drop: got fc=%0d fv=%b en=%b ec=%0d want 0/0/0/0",
               frame_cnt, frame_valid, enables, err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    sync = 1'b0;
    rx_data = '0;
    positions = '0;
    last_acc = 1'b0;
    stim_bad = 1'b0;
    model_reset();
    test_reset();
    test_idle();
    test_valid();
    test_bad_header();
    test_timeout();
    test_boundary();
    test_tx_hold();
    test_checksum();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/rio_frame_io.md
Name: rio_frame_io

Overview:
Parametrised frame I/O core between the network interface (rx_data/tx_data/sync) and the per-channel motion blocks. It unpacks N velocity/enable channels from the PC frame, validates the header, and applies a reset-safe watchdog. It snapshots N position inputs plus a timestamp into a stable TX frame on every transfer. This replaces the fixed three-channel inline packing and watchdog logic in the top level.

Parameters:
BUFFER_SIZE, 160, frame width in bits; multiple of 8; must be >= 64+32*CHANNELS and >= 32+33*CHANNELS (+8 with checksum).
CHANNELS, 3, number of velocity/enable/position channels (1..16).
TIMEOUT, 2700000, watchdog limit in sysclk cycles.
HEADER_RX, 32'h74697277, required PC->FPGA header.
HEADER_TX, 32'h64617461, FPGA->PC header.

Ports:
sysclk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
sync  in  1  transfer-done strobe from interface, asynchronous to frame content.
rx_data  in  BUFFER_SIZE  received frame, MSB-first byte stream.
tx_data  out  BUFFER_SIZE  registered transmit frame.
positions  in  32*CHANNELS  channel i at [32i+31:32i].
velocities  out  32*CHANNELS  registered, channel i at [32i+31:32i].
enables  out  CHANNELS  registered, already gated by watchdog.
timeout  out  1  watchdog state (1 = no valid traffic).
frame_valid  out  1  one-cycle pulse per accepted frame.
frame_cnt  out  16  accepted frames, wraps.
err_cnt  out  16  rejected frames, saturates at 16'hFFFF.

Behaviour:
- Reset is asynchronous and active-high. While asserted: velocities=0, enables=0, timeout=1, frame_valid=0, frame_cnt=0, err_cnt=0, timestamp=0, tx_data={HEADER_TX byte-swapped, zeros}.
- sync passes through a 3-flop shift register; edge = (sr[2:1]==2'b01).
- RX layout, MSB down: header (32 bits), then CHANNELS x 32-bit velocities, each little-endian (byte0 first), then CHANNELS enable bits (ch0 first), then fill. The header is compared after byte swap.
- On edge with header match: on the next clock, latch velocities and enables, pulse frame_valid, increment frame_cnt, clear watchdog. Latency is 1 cycle from edge.
- On edge with header mismatch: outputs are held and err_cnt increments. The watchdog is not cleared.
- Watchdog FSM states:
  - WAIT_FIRST (reset state): timeout=1. Moves to RUN on the first accepted frame.
  - RUN: timeout=0. The counter increments each cycle and clears on an accepted frame. When the counter reaches TIMEOUT, move to EXPIRED.
  - EXPIRED: timeout=1. Moves to RUN on an accepted frame.
- Entering EXPIRED zeroes velocities and enables in the same clock as timeout rises.
- The counter saturates and never wraps.
- Simultaneous accepted frame and counter==TIMEOUT: the frame wins. State becomes RUN, the counter is 0, and timeout stays 0.
- enables = latched_enables & ~timeout, at all times.
- timestamp is a free-running 32-bit counter that wraps at 2^32.
- TX layout, MSB down: HEADER_TX, timestamp, positions ch0..chN-1, each little-endian; remaining bits are 0.
- On edge, tx_data captures the current timestamp and positions. It is updated one cycle after edge and is otherwise held stable regardless of position activity.
- Reset mid-frame drops any pending latch; there is no partial update.

Optional Feature:
RIO_RX_CHECKSUM_EN:
- With: rx_data[7:0] must equal the XOR of all other BUFFER_SIZE/8-1 bytes.
- The XOR result is registered, so RX acceptance latency becomes 2 cycles from edge. TX latency is unchanged.
- Mismatch, or header mismatch, counts as rejected.
- Without: rx_data[7:0] is fill and is ignored; latency is 1 cycle.

Decomposition:
- Package rio_pkg:
  - watchdog state enum {WAIT_FIRST, RUN, EXPIRED};
  - default header constants;
  - byte_swap32 function;
  - localparam helpers for the RX/TX field offsets.
- Sub-module rio_watchdog: counter plus FSM, with inputs kick and rst and outputs timeout and expire_pulse.

Test Plan:
1. Reset release, no sync for TIMEOUT+10 cycles -> timeout=1, enables=0, tx_data header bytes 61,74,61,64 (MSB first).
2. Valid frame: ch0 velocity bytes 10 00 00 00, enable bits 101 -> one cycle after edge: velocities[31:0]=32'h10, enables=3'b101, frame_valid pulse, frame_cnt=1, timeout=0.
3. Frame with header 32'hDEADBEEF -> outputs unchanged, err_cnt increments by 1, watchdog keeps counting.
4. TIMEOUT=100, accepted frame then silence for 100 cycles -> timeout rises at count 100, velocities=0, enables=0. Next valid frame restores the outputs.
5. Accepted frame edge exactly at count==TIMEOUT -> timeout never asserts.
6. positions ch1=32'h01020304, edge, then positions change -> tx ch1 bytes stay 04 03 02 01 until the next edge. With RIO_RX_CHECKSUM_EN, a corrupted checksum byte is rejected (err_cnt+1).
